// File: rtl/jt12_pg_sched_if.sv
// jt12_pg_sched_if: register-bus handshake between the host and the phase-generator scheduler.
//   wr      host -> sched  write request, held high until wr_ack
//   part    host -> sched  0: channels 0-2 and globals, 1: channels 3-5
//   addr    host -> sched  register number
//   din     host -> sched  register data
//   wr_ack  sched -> host  one-clk pulse when the write was sampled
interface jt12_pg_sched_if;
    logic       wr;
    logic       part;
    logic [7:0] addr;
    logic [7:0] din;
    logic       wr_ack;

    modport master (output wr, part, addr, din, input wr_ack);
    modport slave  (input wr, part, addr, din, output wr_ack);
endinterface

// File: rtl/jt12_pg_sched.sv
// jt12_pg_sched: slot scheduler and register front-end for the phase generator.
// Stores per-channel fnum/block/pms and per-operator dt1/mul, walks the 24-slot operator
// sequence and presents each slot's parameters at the stage where the phase generator uses them.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clk_en         slot advance / register-sample enable
//   bus            register write handshake (slave side)
//   slot, zero     current slot 0..23, high while slot==0
//   fnum_I, block_I, pms_I   parameters of the current slot
//   dt1_II         dt1 of slot-1
//   pg_rst_III     phase-reset pulse of slot-2
//   mul_V          mul of slot-4
module jt12_pg_sched (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    jt12_pg_sched_if.slave bus,
    output logic [4:0]     slot,
    output logic           zero,
    output logic [10:0]    fnum_I,
    output logic [2:0]     block_I,
    output logic [2:0]     pms_I,
    output logic [2:0]     dt1_II,
    output logic           pg_rst_III,
    output logic [3:0]     mul_V
);

    // Slot s = 6*op + ch, op in register order S1,S3,S2,S4.
    function automatic logic [1:0] slot_op(input logic [4:0] s);
        if (s >= 5'd18)      return 2'd3;
        else if (s >= 5'd12) return 2'd2;
        else if (s >= 5'd6)  return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [2:0] slot_ch(input logic [4:0] s);
        case (slot_op(s))
            2'd3:    return 3'(s - 5'd18);
            2'd2:    return 3'(s - 5'd12);
            2'd1:    return 3'(s - 5'd6);
            default: return 3'(s);
        endcase
    endfunction

    function automatic logic [4:0] to_slot(input logic [1:0] op, input logic [2:0] ch);
        return ({3'b000, op} * 5'd6) + {2'b00, ch};
    endfunction

    // (s - k) mod 24 for small k
    function automatic logic [4:0] slot_back(input logic [4:0] s, input logic [4:0] k);
        return (s >= k) ? (s - k) : (s + (5'd24 - k));
    endfunction

    // State
    logic [4:0]  slot_q;
    logic        zero_q;
    logic        wr_ack_q;
    logic [10:0] fnum_q     [6];
    logic [2:0]  block_q    [6];
    logic [2:0]  pms_q      [6];
    logic [10:0] sp_fnum_q  [3];
    logic [2:0]  sp_block_q [3];
    logic [2:0]  dt1_q      [24];
    logic [3:0]  mul_q      [24];
    logic [5:0]  latch_n_q;
    logic [5:0]  latch_s_q;
    logic        spmode_q;
    logic [23:0] key_q, key_d;
    logic [23:0] pend_q, pend_d;

    logic [10:0] fnum_s1_q;
    logic [2:0]  block_s1_q;
    logic [2:0]  pms_s1_q;
    logic [2:0]  dt1_s2_q;
    logic        pg_rst_s3_q;
    logic [3:0]  mul_s5_q;

    // Next slot and the slot indices each pipeline stage reads
    logic [4:0]  nxt_slot;
    logic [1:0]  nxt_op;
    logic [2:0]  nxt_ch;
    logic        use_sp;
    logic [10:0] p_fnum;
    logic [2:0]  p_block;
    logic [4:0]  dt1_idx, rst_idx, mul_idx;

    always_comb begin
        nxt_slot = (slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
        nxt_op   = slot_op(nxt_slot);
        nxt_ch   = slot_ch(nxt_slot);
        // Channel 2 in special mode takes S1/S3/S2 frequencies from the special set
        use_sp   = spmode_q && (nxt_ch == 3'd2) && (nxt_op != 2'd3);
        p_fnum   = use_sp ? sp_fnum_q[nxt_op]  : fnum_q[nxt_ch];
        p_block  = use_sp ? sp_block_q[nxt_op] : block_q[nxt_ch];
        dt1_idx  = slot_back(nxt_slot, 5'd1);
        rst_idx  = slot_back(nxt_slot, 5'd2);
        mul_idx  = slot_back(nxt_slot, 5'd4);
    end

    // Write decode
    logic       we;
    logic [1:0] wlo;
    logic       wvalid;
    logic [2:0] wch;
    logic [4:0] wslot;
    logic [1:0] sp_idx;
    logic       dec_opreg, dec_fnum, dec_latn, dec_sp, dec_lats, dec_pms, dec_mode, dec_key;
    logic [2:0] kch;
    logic [3:0] knew;

    always_comb begin
        // wr_ack blocks re-sampling the same request during the ack cycle
        we     = clk_en && bus.wr && !wr_ack_q;
        wlo    = bus.addr[1:0];
        wvalid = (wlo != 2'd3);
        wch    = bus.part ? (3'd3 + {1'b0, wlo}) : {1'b0, wlo};
        wslot  = to_slot(bus.addr[3:2], wch);
        case (wlo)
            2'd1:    sp_idx = 2'd0; // S1
            2'd2:    sp_idx = 2'd2; // S2
            default: sp_idx = 2'd1; // S3
        endcase
        dec_opreg = we && wvalid && (bus.addr[7:4] == 4'h3);
        dec_fnum  = we && wvalid && (bus.addr[7:2] == 6'h28);
        dec_latn  = we && wvalid && (bus.addr[7:2] == 6'h29);
        dec_sp    = we && wvalid && !bus.part && (bus.addr[7:2] == 6'h2A);
        dec_lats  = we && wvalid && !bus.part && (bus.addr[7:2] == 6'h2B);
        dec_pms   = we && wvalid && (bus.addr[7:2] == 6'h2D);
        dec_mode  = we && !bus.part && (bus.addr == 8'h27);
        dec_key   = we && !bus.part && (bus.addr == 8'h28) && (bus.din[1:0] != 2'b11);
        kch       = bus.din[2] ? (3'd3 + {1'b0, bus.din[1:0]}) : {1'b0, bus.din[1:0]};
        // Key bits in op order S1,S3,S2,S4
        knew      = {bus.din[7], bus.din[5], bus.din[6], bus.din[4]};
    end

    // Key edges and pending phase resets; a key-on edge wins over the clear on the same edge
    always_comb begin
        key_d  = key_q;
        pend_d = pend_q;
        if (clk_en) begin
            pend_d[rst_idx] = 1'b0;
        end
        if (dec_key) begin
            for (int i = 0; i < 4; i++) begin
                if (knew[i] && !key_q[to_slot(2'(i), kch)]) begin
                    pend_d[to_slot(2'(i), kch)] = 1'b1;
                end
                key_d[to_slot(2'(i), kch)] = knew[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= 5'd0;
            zero_q      <= 1'b1;
            wr_ack_q    <= 1'b0;
            latch_n_q   <= 6'd0;
            latch_s_q   <= 6'd0;
            spmode_q    <= 1'b0;
            key_q       <= 24'd0;
            pend_q      <= 24'd0;
            fnum_s1_q   <= 11'd0;
            block_s1_q  <= 3'd0;
            pms_s1_q    <= 3'd0;
            dt1_s2_q    <= 3'd0;
            pg_rst_s3_q <= 1'b0;
            mul_s5_q    <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                fnum_q[i]  <= 11'd0;
                block_q[i] <= 3'd0;
                pms_q[i]   <= 3'd0;
            end
            for (int i = 0; i < 3; i++) begin
                sp_fnum_q[i]  <= 11'd0;
                sp_block_q[i] <= 3'd0;
            end
            for (int i = 0; i < 24; i++) begin
                dt1_q[i] <= 3'd0;
                mul_q[i] <= 4'd0;
            end
        end else begin
            wr_ack_q <= we;
            key_q    <= key_d;
            pend_q   <= pend_d;
            // Outputs read pre-edge storage, so a same-edge write shows up one slot later
            if (clk_en) begin
                slot_q      <= nxt_slot;
                zero_q      <= (nxt_slot == 5'd0);
                fnum_s1_q   <= p_fnum;
                block_s1_q  <= p_block;
                pms_s1_q    <= pms_q[nxt_ch];
                dt1_s2_q    <= dt1_q[dt1_idx];
                pg_rst_s3_q <= pend_q[rst_idx];
                mul_s5_q    <= mul_q[mul_idx];
            end
            if (dec_opreg) begin
                dt1_q[wslot] <= bus.din[6:4];
                mul_q[wslot] <= bus.din[3:0];
            end
            if (dec_latn) begin
                latch_n_q <= bus.din[5:0];
            end
            if (dec_fnum) begin
                fnum_q[wch]  <= {latch_n_q[2:0], bus.din};
                block_q[wch] <= latch_n_q[5:3];
            end
            if (dec_lats) begin
                latch_s_q <= bus.din[5:0];
            end
            if (dec_sp) begin
                sp_fnum_q[sp_idx]  <= {latch_s_q[2:0], bus.din};
                sp_block_q[sp_idx] <= latch_s_q[5:3];
            end
            if (dec_pms) begin
                pms_q[wch] <= bus.din[2:0];
            end
            if (dec_mode) begin
                spmode_q <= |bus.din[7:6];
            end
        end
    end

    assign bus.wr_ack = wr_ack_q;
    assign slot       = slot_q;
    assign zero       = zero_q;
    assign fnum_I     = fnum_s1_q;
    assign block_I    = block_s1_q;
    assign pms_I      = pms_s1_q;
    assign dt1_II     = dt1_s2_q;
    assign pg_rst_III = pg_rst_s3_q;
    assign mul_V      = mul_s5_q;

endmodule

// File: tb/tb_jt12_pg_sched.sv
// tb_jt12_pg_sched: bench for jt12_pg_sched. A behavioural model indexed by [operator][channel]
// predicts every output after each clock edge; directed scenarios add fixed-value checks.
module tb_jt12_pg_sched;

    localparam int S1 = 0, S3 = 1, S2 = 2, S4 = 3;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [4:0]  slot;
    logic        zero;
    logic [10:0] fnum_I;
    logic [2:0]  block_I;
    logic [2:0]  pms_I;
    logic [2:0]  dt1_II;
    logic        pg_rst_III;
    logic [3:0]  mul_V;

    jt12_pg_sched_if bus_if ();

    jt12_pg_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .bus        (bus_if),
        .slot       (slot),
        .zero       (zero),
        .fnum_I     (fnum_I),
        .block_I    (block_I),
        .pms_I      (pms_I),
        .dt1_II     (dt1_II),
        .pg_rst_III (pg_rst_III),
        .mul_V      (mul_V)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_slot, m_zero, m_ack;
    int e_fnum, e_block, e_pms, e_dt1, e_rst, e_mul;
    int m_fnum[6], m_block[6], m_pms[6];
    int m_spf[3], m_spb[3];
    int m_dt1[4][6], m_mul[4][6], m_key[4][6], m_pend[4][6];
    int m_latn, m_lats, m_spm;

    function automatic void model_reset();
        m_slot = 0; m_zero = 1; m_ack = 0;
        e_fnum = 0; e_block = 0; e_pms = 0; e_dt1 = 0; e_rst = 0; e_mul = 0;
        m_latn = 0; m_lats = 0; m_spm = 0;
        for (int c = 0; c < 6; c++) begin
            m_fnum[c] = 0; m_block[c] = 0; m_pms[c] = 0;
            for (int o = 0; o < 4; o++) begin
                m_dt1[o][c] = 0; m_mul[o][c] = 0; m_key[o][c] = 0; m_pend[o][c] = 0;
            end
        end
        for (int o = 0; o < 3; o++) begin
            m_spf[o] = 0; m_spb[o] = 0;
        end
    endfunction

    function automatic void set_key(int op, int ch, int on);
        if (on != 0 && m_key[op][ch] == 0) m_pend[op][ch] = 1;
        m_key[op][ch] = on;
    endfunction

    function automatic void model_write(int p, int a, int d);
        int lo, c, o, sel, kc;
        lo = a % 4;
        c  = p * 3 + lo;
        if (lo != 3) begin
            if (a >= 'h30 && a <= 'h3F) begin
                o = (a / 4) % 4;
                m_dt1[o][c] = (d / 16) % 8;
                m_mul[o][c] = d % 16;
            end
            if (a >= 'hA4 && a <= 'hA6) m_latn = d % 64;
            if (a >= 'hA0 && a <= 'hA2) begin
                m_fnum[c]  = (m_latn % 8) * 256 + d;
                m_block[c] = m_latn / 8;
            end
            if (p == 0 && a >= 'hAC && a <= 'hAE) m_lats = d % 64;
            if (p == 0 && a >= 'hA8 && a <= 'hAA) begin
                o = (lo == 1) ? S1 : (lo == 2) ? S2 : S3;
                m_spf[o] = (m_lats % 8) * 256 + d;
                m_spb[o] = m_lats / 8;
            end
            if (a >= 'hB4 && a <= 'hB6) m_pms[c] = d % 8;
        end
        if (p == 0 && a == 'h27) m_spm = (d >= 64) ? 1 : 0;
        if (p == 0 && a == 'h28) begin
            sel = d % 8;
            if (sel != 3 && sel != 7) begin
                kc = (sel < 4) ? sel : sel - 1;
                set_key(S1, kc, (d / 16) % 2);
                set_key(S2, kc, (d / 32) % 2);
                set_key(S3, kc, (d / 64) % 2);
                set_key(S4, kc, (d / 128) % 2);
            end
        end
    endfunction

    function automatic void model_edge(int ce, int w, int p, int a, int d);
        int fire, ns, op, ch, k;
        fire = (ce != 0 && w != 0 && m_ack == 0) ? 1 : 0;
        if (ce != 0) begin
            ns = (m_slot + 1) % 24;
            op = ns / 6;
            ch = ns % 6;
            if (m_spm != 0 && ch == 2 && op != S4) begin
                e_fnum = m_spf[op]; e_block = m_spb[op];
            end else begin
                e_fnum = m_fnum[ch]; e_block = m_block[ch];
            end
            e_pms = m_pms[ch];
            k = (ns + 23) % 24; e_dt1 = m_dt1[k / 6][k % 6];
            k = (ns + 20) % 24; e_mul = m_mul[k / 6][k % 6];
            k = (ns + 22) % 24; e_rst = m_pend[k / 6][k % 6];
            m_pend[k / 6][k % 6] = 0;
            m_slot = ns;
            m_zero = (ns == 0) ? 1 : 0;
        end
        if (fire != 0) model_write(p, a, d);
        m_ack = fire;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic compare_all();
        check_val("slot", 32'(slot), m_slot);
        check_val("zero", 32'(zero), m_zero);
        check_val("wr_ack", 32'(bus_if.wr_ack), m_ack);
        check_val("fnum_I", 32'(fnum_I), e_fnum);
        check_val("block_I", 32'(block_I), e_block);
        check_val("pms_I", 32'(pms_I), e_pms);
        check_val("dt1_II", 32'(dt1_II), e_dt1);
        check_val("pg_rst_III", 32'(pg_rst_III), e_rst);
        check_val("mul_V", 32'(mul_V), e_mul);
    endtask

    task automatic cyc(input logic ce);
        clk_en = ce;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(int'(ce), int'(bus_if.wr), int'(bus_if.part), int'(bus_if.addr),
                        int'(bus_if.din));
        #1;
        compare_all();
        if (pg_rst_III === 1'b1) pulse_cnt++;
    endtask

    task automatic bus_write(input logic p, input logic [7:0] a, input logic [7:0] d,
                             input bit rnd_ce, input int hold);
        bus_if.part = p;
        bus_if.addr = a;
        bus_if.din  = d;
        bus_if.wr   = 1'b1;
        for (int n = 0; n < 64; n++) begin
            cyc(rnd_ce ? logic'($urandom_range(0, 2) != 0) : 1'b1);
            if (bus_if.wr_ack === 1'b1) break;
        end
        check_val("wr_ack_seen", 32'(bus_if.wr_ack), 1);
        for (int h = 0; h < hold; h++) cyc(logic'($urandom_range(0, 1)));
        bus_if.wr = 1'b0;
    endtask

    task automatic run_to_slot(input int t);
        for (int n = 0; n < 60; n++) begin
            if (slot == 5'(t)) break;
            cyc(1'b1);
        end
        check_val("reach_slot", 32'(slot), t);
    endtask

    task automatic run_ce(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int zc;
        logic [7:0] ra;
        rst_n = 1'b0;
        clk_en = 1'b0;
        bus_if.wr = 1'b0;
        bus_if.part = 1'b0;
        bus_if.addr = 8'h00;
        bus_if.din = 8'h00;
        model_reset();
        cyc(1'b1);
        cyc(1'b0);
        rst_n = 1'b1;

        // Idle walk: zero at slot 0 only, once per 24 pulses
        zc = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1);
            if (zero === 1'b1) zc++;
        end
        check_val("zero_count", zc, 2);

        // Channel 4 frequency through the latch
        bus_write(1'b1, 8'hA5, 8'h22, 1'b1, 0);
        run_ce(3);
        bus_write(1'b1, 8'hA1, 8'h69, 1'b1, 0);
        run_to_slot(4);
        check_val("ch4_s1_fnum", 32'(fnum_I), 'h269);
        check_val("ch4_s1_block", 32'(block_I), 4);
        cyc(1'b1);
        check_val("ch5_fnum", 32'(fnum_I), 0);
        run_to_slot(16);
        check_val("ch4_s2_fnum", 32'(fnum_I), 'h269);
        run_to_slot(22);
        check_val("ch4_s4_fnum", 32'(fnum_I), 'h269);

        // dt1/mul of slot 20 (S4 ch2): dt1 one slot later, mul four later (wraps to slot 0)
        bus_write(1'b0, 8'h3E, 8'h57, 1'b0, 0);
        run_to_slot(21);
        check_val("dt1_slot20", 32'(dt1_II), 5);
        cyc(1'b1);
        check_val("dt1_slot21", 32'(dt1_II), 0);
        run_to_slot(0);
        check_val("mul_slot20", 32'(mul_V), 7);
        cyc(1'b1);
        check_val("mul_slot21", 32'(mul_V), 0);

        // Key-on edges for channel 4
        bus_write(1'b0, 8'h28, 8'hF5, 1'b1, 0);
        pulse_cnt = 0;
        run_ce(48);
        check_val("keyon_pulses", pulse_cnt, 4);
        bus_write(1'b0, 8'h28, 8'hF5, 1'b1, 0);
        pulse_cnt = 0;
        run_ce(48);
        check_val("rekey_pulses", pulse_cnt, 0);
        bus_write(1'b0, 8'h28, 8'h05, 1'b1, 0);
        bus_write(1'b0, 8'h28, 8'hF5, 1'b1, 0);
        pulse_cnt = 0;
        run_ce(48);
        check_val("keyon2_pulses", pulse_cnt, 4);

        // Special mode for channel 2
        bus_write(1'b0, 8'h27, 8'h40, 1'b1, 0);
        bus_write(1'b0, 8'hAD, 8'h0A, 1'b1, 0);
        bus_write(1'b0, 8'hA9, 8'h11, 1'b1, 0);
        run_to_slot(2);
        check_val("sp_s1_fnum", 32'(fnum_I), 'h211);
        check_val("sp_s1_block", 32'(block_I), 1);
        bus_write(1'b0, 8'hA4, 8'h08, 1'b1, 0);
        bus_write(1'b0, 8'hA2, 8'h33, 1'b1, 0);
        run_to_slot(20);
        check_val("ch2_s4_fnum", 32'(fnum_I), 'h033);
        check_val("ch2_s4_block", 32'(block_I), 1);
        bus_write(1'b0, 8'h27, 8'h00, 1'b1, 0);
        run_to_slot(2);
        check_val("ch2_s1_norm", 32'(fnum_I), 'h033);

        // Reset with pending phase resets outstanding
        run_to_slot(10);
        bus_write(1'b0, 8'h28, 8'h05, 1'b0, 0);
        bus_write(1'b0, 8'h28, 8'hF5, 1'b0, 0);
        run_to_slot(13);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_slot", 32'(slot), 0);
        check_val("rst_zero", 32'(zero), 1);
        compare_all();
        cyc(1'b1);
        #3;
        rst_n = 1'b1;
        pulse_cnt = 0;
        run_ce(48);
        check_val("post_rst_pulses", pulse_cnt, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 9))
                0: ra = 8'h30 + 8'($urandom_range(0, 15));
                1: ra = 8'hA0 + 8'($urandom_range(0, 3));
                2: ra = 8'hA4 + 8'($urandom_range(0, 3));
                3: ra = 8'hA8 + 8'($urandom_range(0, 3));
                4: ra = 8'hAC + 8'($urandom_range(0, 3));
                5: ra = 8'hB4 + 8'($urandom_range(0, 3));
                6: ra = 8'h27;
                7: ra = 8'h28;
                8: ra = 8'($urandom_range(0, 255));
                default: ra = 8'h00;
            endcase
            if (ra == 8'h00) begin
                for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                    cyc(logic'($urandom_range(0, 3) != 0));
            end else begin
                bus_write(logic'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)),
                          1'b1, int'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                cyc(1'b0);
                #3;
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt12_pg_sched.md
# jt12_pg_sched

Slot scheduler and register front-end for the phase generator. Holds per-channel frequency/PMS and per-operator DT1/MUL state, written from the register bus. Runs the 24-slot operator sequence and presents each slot's parameters at the pipeline stage where the phase generator consumes them. Also tracks key-on edges and issues the phase-reset pulse for each operator exactly once.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- clk_en  in  1  slot advance / register-sample enable
- wr  in  1  write request; held high until wr_ack
- part  in  1  0: channels 0-2 and globals; 1: channels 3-5
- addr  in  8  register number
- din  in  8  register data
- wr_ack  out  1  one-clk pulse when the write was sampled
- slot  out  5  current slot 0..23
- zero  out  1  high while slot==0
- fnum_I  out  11  F-number for slot
- block_I  out  3  block for slot
- pms_I  out  3  PMS for slot
- dt1_II  out  3  DT1 for slot-1
- pg_rst_III  out  1  phase reset for slot-2
- mul_V  out  4  MUL for slot-4

## Operation
- Slot index s = 6*op + ch, where op 0..3 = S1,S3,S2,S4 (register order) and ch 0..5.
- Channel c = part*3 + addr[1:0]. Writes with addr[1:0]==3 are ignored, as are unlisted addresses.
- Registers:
  - 0x30-0x3F: dt1 = din[6:4], mul = din[3:0] for (op = addr[3:2], c).
  - 0xA4-0xA6: latch_n = din[5:0].
  - 0xA0-0xA2: fnum[c] = {latch_n[2:0], din}, block[c] = latch_n[5:3].
  - 0xAC-0xAE: latch_s = din[5:0] (part 0 only).
  - 0xA8-0xAA: special fnum/block for ch2 operator: addr[1:0] 1→S1, 2→S2, 0→S3 (part 0 only).
  - 0xB4-0xB6: pms[c] = din[2:0].
  - 0x27 (part 0): spmode = |din[7:6].
  - 0x28 (part 0): ch sel din[2:0], where 0-2→ch 0-2 and 4-6→ch 3-5; 3 and 7 are ignored. Keys: din[4]=S1, din[5]=S2, din[6]=S3, din[7]=S4.
- Key handling: each operator has a key bit and a pending bit.
  - A 0→1 key transition sets pending.
  - 1→1 and 1→0 do not set pending; key-off never resets phase.
- Frequency source: when spmode=1 and ch==2 and op≠S4, fnum/block come from the special set. Otherwise they come from the channel set.
- Pipeline outputs: for each clk_en edge that loads slot=s, register:
  - fnum_I/block_I/pms_I ← params(s)
  - dt1_II ← dt1(s-1)
  - pg_rst_III ← pending(s-2)
  - mul_V ← mul(s-4)
  - All indices are mod 24.
- Issuing pg_rst_III=1 for slot t clears pending(t) on the same edge.
- Key-on race: a key-on edge that sets pending(t) on the same edge that clears it leaves pending=1, so set wins. The reset is issued again on the next visit.

## Timing
- Reset (rst_n low, async):
  - slot=0, zero=1, wr_ack=0, all outputs 0.
  - All register arrays, latches, spmode, keys and pending cleared.
- Slot counter advances 0..23 and wraps to 0, only on clk_en edges. zero is registered and tracks slot==0.
- Writes:
  - wr is sampled on the first clk edge with clk_en=1 while wr=1; wr_ack is high for the following clk cycle.
  - The host deasserts wr after wr_ack; wr still high one cycle after wr_ack is a new write.
  - A sampled write is visible to slot outputs from the next clk_en edge onward.
- Latch/commit order:
  - Writing the latch alone does not change fnum/block.
  - Two commits after one latch write both use the same latch value.
- Parameter-write vs. output-load race: a write to a register being read in the same edge does not affect that edge's outputs; old values are output.
- rst_n asserted mid-sequence returns to slot 0 immediately. No pg_rst is emitted for keys set before reset.

## Test plan
- Reset, then 48 clk_en pulses:
  - zero high at slot 0 only, every 24 pulses; all parameter outputs 0.
- Write 0xA5=0x22, then 0xA1=0x69 (part 1):
  - at slot 4 (ch4, S1), fnum_I=0x269, block_I=4;
  - at slots 10/16/22 same values;
  - other channels 0.
- Write 0x3E=0x57 (part 0):
  - dt1_II=5 one clk_en after slot 20 is loaded;
  - mul_V=7 four clk_en after slot 20 is loaded;
  - both 0 elsewhere.
- Write 0x28=0xF5 (ch4 all keys on):
  - pg_rst_III=1 exactly once for slots 4, 10, 16, 22, each two clk_en after that slot loads;
  - repeat the 0x28=0xF5 write: no further pulses;
  - 0x28=0x05 then 0xF5 again: pulses again.
- spmode:
  - 0x27=0x40, 0xAD=0x0A, 0xA9=0x11: slot 2 (ch2 S1) shows fnum 0x211, block 1.
  - 0xA4=0x08, 0xA2=0x33: slot 20 (ch2 S4) shows fnum 0x033, block 1.
  - 0x27=0x00: slot 2 reverts to the channel set.
- Drop rst_n during slot 13 with pending bits set:
  - immediate slot=0, all outputs 0;
  - after release, no pg_rst_III pulses appear.
